spi_regfile_periph: RTL and testbench



---
 rtl/spi_regfile_periph.sv | 179 +++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral fronting a NUM_REGS x DATA_W control register bank.
// Define SPI_READBACK_EN to build the CIPO read path; otherwise CIPO/cipo_oe are tied low.
module spi_regfile_periph #(
    parameter int NUM_REGS   = 5,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int SYNC_FLOPS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int WARM_W  = $clog2(SYNC_FLOPS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_OVER  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ADDR  = CNT_W'(ADDR_W);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_FLOPS);
    localparam logic [ADDR_W:0]   REGS_LIM  = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_FLOPS-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                  sclk_hist, ncs_hist;
    logic                  sclk_s, copi_s, ncs_s;
    logic                  sclk_rise, ncs_rise, ncs_fall;
    logic [WARM_W-1:0]     warm_cnt;
    logic                  armed;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_W-1:0]    shreg;
    logic                  start, shift_en;
    logic                  f_rw;
    logic [ADDR_W-1:0]     f_addr;
    logic [DATA_W-1:0]     f_data;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_FLOPS-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_FLOPS-2:0], COPI};
            ncs_sync  <= {ncs_sync[SYNC_FLOPS-2:0], nCS};
            sclk_hist <= sclk_s;
            ncs_hist  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_FLOPS-1];
    assign copi_s    = copi_sync[SYNC_FLOPS-1];
    assign ncs_s     = ncs_sync[SYNC_FLOPS-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ncs_rise  = ncs_s & ~ncs_hist;
    assign ncs_fall  = ~ncs_s & ncs_hist & armed;

    // Frames only start once the synchroniser has flushed its reset value and seen nCS high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + 1'b1;
        end else if (ncs_s) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign f_rw   = shreg[FRAME_W-1];
    assign f_addr = shreg[DATA_W +: ADDR_W];
    assign f_data = shreg[DATA_W-1:0];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        wr_strobe = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE:   if (ncs_fall) state_d = SHIFT;
            SHIFT:  if (ncs_rise) state_d = COMMIT;
            COMMIT: begin
                state_d = IDLE;
                if (bit_cnt == CNT_FULL)
                    wr_strobe = f_rw && ({1'b0, f_addr} < REGS_LIM);
                else if (bit_cnt != '0)
                    frame_err = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start    = (state_q == IDLE) && ncs_fall;
    assign shift_en = (state_q == SHIFT) && sclk_rise && !ncs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[FRAME_W-2:0], copi_s};
            if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // NOTE: the bank is a handful of control flops driving pads, so it does carry a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_addr <= '0;
        end else if (wr_strobe) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (f_addr == ADDR_W'(i)) regs[i] <= f_data;
            wr_addr <= f_addr;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs[i];
    end

`ifdef SPI_READBACK_EN
    logic              sclk_fall, load;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W:0]   out_sh;

    assign sclk_fall = ~sclk_s & sclk_hist;
    assign rd_addr   = {shreg[ADDR_W-2:0], copi_s};
    assign load      = shift_en && (bit_cnt == CNT_ADDR) && !shreg[ADDR_W-1];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end

    // Leading zero pad: the falling edge after the last address bit puts the data MSB on CIPO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_sh <= '0;
        else if (start)
            out_sh <= '0;
        else if (load)
            out_sh <= {1'b0, rd_data};
        else if ((state_q == SHIFT) && sclk_fall && !ncs_s)
            out_sh <= {out_sh[DATA_W-1:0], 1'b0};
    end

    assign cipo_oe = ~ncs_s;
    assign CIPO    = out_sh[DATA_W] & ~ncs_s;
`else
    assign cipo_oe = 1'b0;
    assign CIPO    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Randomised self-checking bench for spi_regfile_periph against a frame-level reference model.
// Honours SPI_READBACK_EN the same way as the design.
module tb_spi_regfile_periph;

    localparam int NUM_REGS   = 5;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int SYNC_FLOPS = 2;
    localparam int FRAME_W    = 1 + ADDR_W + DATA_W;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n, SCLK, COPI, nCS;
    logic                       CIPO, cipo_oe, wr_strobe, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic [ADDR_W-1:0]          wr_addr;

    spi_regfile_periph #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_FLOPS(SYNC_FLOPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pulse monitor, sampled away from the active edge.
    int   strb_cycles = 0, strb_pulses = 0, err_cycles = 0;
    logic strb_prev   = 1'b0;
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strb_cycles++;
        if (wr_strobe === 1'b1 && strb_prev !== 1'b1) strb_pulses++;
        if (frame_err === 1'b1) err_cycles++;
        strb_prev = wr_strobe;
    end

    // Reference model: register contents and cumulative event counts.
    logic [DATA_W-1:0] exp_regs [NUM_REGS];
    logic [ADDR_W-1:0] exp_wr_addr;
    int                exp_strb = 0, exp_err = 0;

    function automatic logic [NUM_REGS*DATA_W-1:0] exp_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = exp_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        exp_wr_addr = '0;
    endtask

    // What a frame of nbits should do; exp_rd is what the controller should clock in on CIPO.
    task automatic model_frame(input logic [31:0] bits, input int nbits,
                               output logic [15:0] exp_rd, output bit rd_valid);
        logic [6:0] addr;
        logic [7:0] data;
        exp_rd   = '0;
        rd_valid = 1'b0;
        if (nbits == FRAME_W) begin
            addr = bits[14:8];
            data = bits[7:0];
            if (bits[15]) begin
                if (int'(addr) < NUM_REGS) begin
                    exp_regs[addr] = data;
                    exp_wr_addr    = addr;
                    exp_strb++;
                end
            end else begin
                rd_valid = 1'b1;
                if (RB && int'(addr) < NUM_REGS) exp_rd = {8'h00, exp_regs[addr]};
            end
        end else if (nbits > 0) begin
            exp_err++;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // SPI controller: mode 0, MSB first, samples CIPO just before each rising SCLK.
    task automatic drive_frame(input logic [31:0] bits, input int nbits, input int gap,
                               input int half, output logic [31:0] rd, output logic oe_mid);
        rd = '0;
        wait_clks(gap);
        nCS = 1'b0;
        wait_clks(half + 2);
        oe_mid = cipo_oe;
        for (int i = 0; i < nbits; i++) begin
            COPI = bits[nbits-1-i];
            wait_clks(half);
            rd   = {rd[30:0], CIPO};
            SCLK = 1'b1;
            wait_clks(half);
            SCLK = 1'b0;
        end
        wait_clks(half);
        nCS  = 1'b1;
        COPI = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ":strobe_pulses"}, strb_pulses, exp_strb);
        check({tag, ":strobe_cycles"}, strb_cycles, exp_strb);
        check({tag, ":frame_err"}, err_cycles, exp_err);
        check({tag, ":wr_addr"}, wr_addr, exp_wr_addr);
        check({tag, ":regs_out"}, regs_out, exp_flat());
        check({tag, ":cipo_oe_idle"}, cipo_oe, 1'b0);
        check({tag, ":cipo_idle"}, CIPO, 1'b0);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] bits, input int nbits,
                             input int half);
        logic [15:0] exp_rd;
        bit          rd_valid;
        logic [31:0] rd;
        logic        oe_mid;
        model_frame(bits, nbits, exp_rd, rd_valid);
        drive_frame(bits, nbits, 4, half, rd, oe_mid);
        wait_clks(10);
        check_state(tag);
        if (rd_valid) begin
            check({tag, ":readback"}, rd[15:0], exp_rd);
            check({tag, ":cipo_oe_sel"}, oe_mid, RB);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] er;
        bit          rv;
        logic [31:0] rd;
        logic        oe;
        rst_n = 1'b0; SCLK = 1'b0; COPI = 1'b0; nCS = 1'b1;
        model_reset();
        wait_clks(3);
        check("reset:regs_out", regs_out, '0);
        check("reset:cipo", CIPO, 1'b0);
        check("reset:cipo_oe", cipo_oe, 1'b0);
        check("reset:wr_strobe", wr_strobe, 1'b0);
        check("reset:frame_err", frame_err, 1'b0);
        check("reset:wr_addr", wr_addr, '0);
        rst_n = 1'b1;
        wait_clks(6);

        run_frame("wr_reg2", 32'h82A5, 16, 5);
        run_frame("wr_reg4", 32'h843C, 16, 6);
        run_frame("rd_reg4", 32'h0400, 16, 5);
        run_frame("wr_addr5", 32'h85FF, 16, 5);
        run_frame("rd_addr6", 32'h0600, 16, 7);
        run_frame("short10", 32'h81FF >> 6, 10, 5);
        run_frame("long17", (32'h81FF << 1) | 32'h1, 17, 5);
        run_frame("empty", 32'h0, 0, 5);

        // Reset mid-frame, released with nCS still low: the block must wait for a fresh frame.
        nCS = 1'b0;
        wait_clks(7);
        for (int i = 0; i < 8; i++) begin
            COPI = (8'h81 >> (7 - i)) & 1'b1;
            wait_clks(5); SCLK = 1'b1; wait_clks(5); SCLK = 1'b0;
        end
        rst_n = 1'b0;
        model_reset();
        wait_clks(3);
        check("midreset:regs_out", regs_out, '0);
        check("midreset:wr_addr", wr_addr, '0);
        rst_n = 1'b1;
        wait_clks(4);
        for (int i = 0; i < 8; i++) begin
            COPI = $urandom_range(0, 1);
            wait_clks(5); SCLK = 1'b1; wait_clks(5); SCLK = 1'b0;
        end
        wait_clks(5);
        nCS = 1'b1;
        wait_clks(10);
        check_state("post_reset");
        run_frame("wr_reg0", 32'h8011, 16, 5);

        // Back-to-back writes with the minimum nCS high time between them.
        model_frame(32'h805A, 16, er, rv);
        drive_frame(32'h805A, 16, 4, 5, rd, oe);
        model_frame(32'h83C3, 16, er, rv);
        drive_frame(32'h83C3, 16, 2, 5, rd, oe);
        wait_clks(10);
        check_state("b2b");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] bits;
            int          nbits;
            if ($urandom_range(0, 3) == 0) begin
                nbits = $urandom_range(0, 20);
                bits  = $urandom;
            end else begin
                nbits = FRAME_W;
                bits  = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 6)),
                         8'($urandom)};
            end
            run_frame("random", bits, nbits, $urandom_range(5, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
